// File: rtl/pipealu_issue_if.sv
// pipealu_issue_if
// Purpose: groups the host-side FIFO write port, run control, status and
// the issue bus of pipealu_issue into one bundle.
// Signals:
//   wr_en, wr_instr   host enqueue strobe and 16-bit instruction
//   full, empty       FIFO occupancy flags
//   count             FIFO occupancy (ADDR_W+1 bits)
//   start             begin issuing (pulse or level)
//   busy, done        run status, one-cycle completion pulse
//   instr             registered instruction to pipealu
//   issue_valid       instr is a real dequeued instruction
//   ovf_err           sticky write-while-full flag
// Modports: master = host side, slave = issue unit.
interface pipealu_issue_if #(
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [15:0]       wr_instr;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              start;
  logic              busy;
  logic              done;
  logic [15:0]       instr;
  logic              issue_valid;
  logic              ovf_err;

  modport master (
    output wr_en, wr_instr, start,
    input  full, empty, count, busy, done, instr, issue_valid, ovf_err
  );

  modport slave (
    input  wr_en, wr_instr, start,
    output full, empty, count, busy, done, instr, issue_valid, ovf_err
  );
endinterface

// File: rtl/pipealu_issue.sv
// pipealu_issue
// Purpose: instruction issue unit in front of pipealu. Buffers host-written
// instructions in a FIFO, streams them one per cycle after start, inserts
// 16'hf000 bubbles on read-after-write hazards against instructions still
// in the ALU pipeline, then drains with HAZ_DEPTH no-ops and pulses done.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   pipealu_issue_if.slave (write port, control, status, issue bus)
module pipealu_issue #(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int HAZ_DEPTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  pipealu_issue_if.slave      bus
);

  localparam logic [15:0]     NOP      = 16'hf000;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam int              DCW      = (HAZ_DEPTH > 1) ? $clog2(HAZ_DEPTH) : 1;
  localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(HAZ_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                       r_state;
  logic [15:0]                  r_mem [DEPTH];
  logic [ADDR_W-1:0]            r_wr_ptr;
  logic [ADDR_W-1:0]            r_rd_ptr;
  logic [ADDR_W:0]              r_count;
  logic                         r_ovf;
  logic [15:0]                  r_instr;
  logic                         r_issue_valid;
  logic                         r_done;
  logic [DCW-1:0]               r_drain_cnt;
  logic [HAZ_DEPTH-1:0]         r_sb_valid;
  logic [HAZ_DEPTH-1:0][3:0]    r_sb_rd;

  logic                         w_full;
  logic                         w_empty;
  logic [15:0]                  w_head;
  logic                         w_head_nop;
  logic [HAZ_DEPTH-1:0]         w_hit;
  logic                         w_hazard;
  logic                         w_pop;
  logic                         w_wr_acc;
  logic                         w_shift;
  logic                         w_sb_in_valid;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  // Head is read combinationally so the hazard check sees it in the same
  // cycle as the pop decision.
  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_nop = (w_head[15:12] == 4'hf);

  // Compare the head's sources against every in-flight destination.
  generate
    for (genvar gi = 0; gi < HAZ_DEPTH; gi++) begin : g_hit
      assign w_hit[gi] = r_sb_valid[gi] &&
                         ((r_sb_rd[gi] == w_head[11:8]) ||
                          (r_sb_rd[gi] == w_head[7:4]));
    end
  endgenerate

  assign w_hazard      = !w_empty && !w_head_nop && (|w_hit);
  assign w_pop         = (r_state == S_RUN) && !w_empty && !w_hazard;
  assign w_wr_acc      = bus.wr_en && !w_full;
  assign w_shift       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_sb_in_valid = w_pop && !w_head_nop;

  // FIFO storage: no reset, stale contents are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.wr_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Full blocks the write even when a pop frees a slot this edge.
      if (bus.wr_en && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Scoreboard: stage 0 takes the slot just issued, older slots shift on.
  generate
    for (genvar gi = 0; gi < HAZ_DEPTH; gi++) begin : g_sb
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sb_valid[gi] <= 1'b0;
          r_sb_rd[gi]    <= 4'h0;
        end else if (w_shift) begin
          if (gi == 0) begin
            r_sb_valid[gi] <= w_sb_in_valid;
            r_sb_rd[gi]    <= w_head[3:0];
          end else begin
            r_sb_valid[gi] <= r_sb_valid[(gi == 0) ? 0 : gi-1];
            r_sb_rd[gi]    <= r_sb_rd[(gi == 0) ? 0 : gi-1];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_instr       <= NOP;
      r_issue_valid <= 1'b0;
      r_done        <= 1'b0;
      r_drain_cnt   <= '0;
    end else begin
      r_instr       <= NOP;
      r_issue_valid <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !w_empty) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_empty) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= '0;
          end else if (!w_hazard) begin
            r_instr       <= w_head;
            r_issue_valid <= !w_head_nop;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.count       = r_count;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.instr       = r_instr;
  assign bus.issue_valid = r_issue_valid;
  assign bus.ovf_err     = r_ovf;

endmodule

// File: tb/tb_pipealu_issue.sv
module tb_pipealu_issue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipealu_issue_if #(.ADDR_W(3)) bus ();

  pipealu_issue #(.DEPTH(8), .ADDR_W(3), .HAZ_DEPTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string              name;
    int                 n_in;
    logic [0:3][15:0]   prog;
    int                 n_out;
    logic [0:5][15:0]   exp_instr;
    logic [0:5]         exp_valid;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic        valid;
  } exp_t;

  vec_t vecs [4];
  exp_t q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] d);
    bus.wr_en    = 1'b1;
    bus.wr_instr = d;
    tick();
    bus.wr_en    = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_issue(input string name);
    exp_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s: scoreboard empty, nothing expected", name);
    end else begin
      e = q.pop_front();
      $display("[TB] %s: instr=%h valid=%b (expect %h/%b)", name, bus.instr, bus.issue_valid, e.instr, e.valid);
      chk({name, " instr"}, bus.instr, e.instr);
      chk({name, " valid"}, {15'd0, bus.issue_valid}, {15'd0, e.valid});
    end
  endtask

  task automatic check_drain(input string name);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk({name, " drain instr"}, bus.instr, 16'hf000);
      chk({name, " drain busy"}, {15'd0, bus.busy}, 16'd1);
    end
    tick();
    $display("[TB] %s: done=%b busy=%b", name, bus.done, bus.busy);
    chk({name, " done"}, {15'd0, bus.done}, 16'd1);
    chk({name, " idle busy"}, {15'd0, bus.busy}, 16'd0);
    tick();
    chk({name, " done pulse"}, {15'd0, bus.done}, 16'd0);
  endtask

  initial begin
    bus.wr_en    = 1'b0;
    bus.wr_instr = 16'h0000;
    bus.start    = 1'b0;

    vecs[0].name = "indep";
    vecs[0].n_in = 3;  vecs[0].prog = {16'h0562, 16'h1345, 16'h69ab, 16'h0000};
    vecs[0].n_out = 3;
    vecs[0].exp_instr = {16'h0562, 16'h1345, 16'h69ab, 16'h0, 16'h0, 16'h0};
    vecs[0].exp_valid = 6'b111000;

    vecs[1].name = "raw";
    vecs[1].n_in = 2;  vecs[1].prog = {16'h2678, 16'h2891, 16'h0, 16'h0};
    vecs[1].n_out = 5;
    vecs[1].exp_instr = {16'h2678, 16'hf000, 16'hf000, 16'hf000, 16'h2891, 16'h0};
    vecs[1].exp_valid = 6'b100010;

    vecs[2].name = "qnop";
    vecs[2].n_in = 2;  vecs[2].prog = {16'hf000, 16'h0218, 16'h0, 16'h0};
    vecs[2].n_out = 2;
    vecs[2].exp_instr = {16'hf000, 16'h0218, 16'h0, 16'h0, 16'h0, 16'h0};
    vecs[2].exp_valid = 6'b010000;

    // rt hazard against an entry two slots deep: two bubbles only
    vecs[3].name = "raw_rt";
    vecs[3].n_in = 3;  vecs[3].prog = {16'h5123, 16'h6456, 16'h7735, 16'h0};
    vecs[3].n_out = 5;
    vecs[3].exp_instr = {16'h5123, 16'h6456, 16'hf000, 16'hf000, 16'h7735, 16'h0};
    vecs[3].exp_valid = 6'b110010;

    // reset state
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst instr", bus.instr, 16'hf000);
    chk("rst count", {12'd0, bus.count}, 16'd0);
    chk("rst empty", {15'd0, bus.empty}, 16'd1);
    chk("rst full", {15'd0, bus.full}, 16'd0);
    chk("rst busy", {15'd0, bus.busy}, 16'd0);
    chk("rst ovf", {15'd0, bus.ovf_err}, 16'd0);

    // asynchronous reset mid-cycle clears a non-empty FIFO immediately
    wr(16'h0562);
    chk("pre-rst count", {12'd0, bus.count}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("async rst count", {12'd0, bus.count}, 16'd0);
    chk("async rst empty", {15'd0, bus.empty}, 16'd1);
    rst = 1'b0;
    tick();

    // start with empty FIFO is ignored
    pulse_start();
    tick();
    chk("empty start busy", {15'd0, bus.busy}, 16'd0);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vecs[v].n_in; i++) wr(vecs[v].prog[i]);
      for (int j = 0; j < vecs[v].n_out; j++) begin
        q.push_back('{instr: vecs[v].exp_instr[j], valid: vecs[v].exp_valid[j]});
      end
      chk({vecs[v].name, " count"}, {12'd0, bus.count}, 16'(vecs[v].n_in));
      pulse_start();
      chk({vecs[v].name, " start instr"}, bus.instr, 16'hf000);
      chk({vecs[v].name, " start busy"}, {15'd0, bus.busy}, 16'd1);
      for (int j = 0; j < vecs[v].n_out; j++) begin
        tick();
        check_issue(vecs[v].name);
      end
      check_drain(vecs[v].name);
    end

    // overflow
    for (int i = 0; i < 9; i++) begin
      wr({12'h000, 4'(i + 1)});
      if (i < 8) q.push_back('{instr: {12'h000, 4'(i + 1)}, valid: 1'b1});
      if (i == 7) begin
        chk("ovf full", {15'd0, bus.full}, 16'd1);
        chk("ovf count8", {12'd0, bus.count}, 16'd8);
        chk("ovf not yet", {15'd0, bus.ovf_err}, 16'd0);
      end
    end
    chk("ovf count", {12'd0, bus.count}, 16'd8);
    chk("ovf err", {15'd0, bus.ovf_err}, 16'd1);
    pulse_start();
    for (int j = 0; j < 8; j++) begin
      tick();
      check_issue("ovf");
    end
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
        tick();
        if (bus.done) seen = 1'b1;
      end
      chk("ovf done seen", {15'd0, seen}, 16'd1);
    end
    chk("ovf drained count", {12'd0, bus.count}, 16'd0);
    chk("ovf sticky", {15'd0, bus.ovf_err}, 16'd1);

    // reset mid-run
    wr(16'h7cde);
    wr(16'hccef);
    wr(16'h2678);
    q.push_back('{instr: 16'h7cde, valid: 1'b1});
    pulse_start();
    tick();
    check_issue("midrun");
    #2 rst = 1'b1;
    #1;
    chk("midrun rst instr", bus.instr, 16'hf000);
    chk("midrun rst busy", {15'd0, bus.busy}, 16'd0);
    chk("midrun rst count", {12'd0, bus.count}, 16'd0);
    chk("midrun rst valid", {15'd0, bus.issue_valid}, 16'd0);
    chk("midrun rst ovf", {15'd0, bus.ovf_err}, 16'd0);
    rst = 1'b0;
    tick();
    pulse_start();
    tick();
    tick();
    chk("post-rst start busy", {15'd0, bus.busy}, 16'd0);
    chk("post-rst instr", bus.instr, 16'hf000);
    chk("post-rst valid", {15'd0, bus.issue_valid}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipealu_issue.md
Name: pipealu_issue

Overview:
- Instruction issue unit that sits in front of pipealu and drives its 16-bit instr input.
- A host writes 16-bit ALU instructions into an internal FIFO. On start, the block streams them to the ALU one per cycle.
- It inserts no-op bubbles (16'hf000) when a queued instruction reads a register written by an instruction still in the ALU pipeline.
- It drains the pipeline with trailing no-ops and reports completion.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.
- ADDR_W, 3, log2(DEPTH).
- HAZ_DEPTH, 3, issue slots a destination register stays in flight (pipealu result latency in slots).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high; clears all state.
- wr_en  input  1  host write strobe for wr_instr.
- wr_instr  input  16  instruction to enqueue: [15:12] opcode, [11:8] rs, [7:4] rt, [3:0] rd.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  ADDR_W+1  current FIFO occupancy.
- start  input  1  begin issuing; single-cycle pulse or level.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse at the end of DRAIN.
- instr  output  16  registered instruction to pipealu.
- issue_valid  output  1  high when instr carries a real (non-bubble) dequeued instruction.
- ovf_err  output  1  sticky: a write arrived while full.

Behaviour:
- Reset (rst=1, asynchronous):
  - instr=16'hf000, issue_valid=0, busy=0, done=0, ovf_err=0.
  - count=0, empty=1, full=0; FIFO pointers zeroed.
  - Scoreboard cleared; state=IDLE.
  - Reset asserted mid-RUN or mid-DRAIN flushes the queue and all in-flight tracking.
- FIFO:
  - full and empty are decoded from registered count.
  - A write is accepted when wr_en=1 and full=0 at the edge.
  - wr_en=1 with full=1 drops the write and sets ovf_err; ovf_err clears only on reset.
  - A write and a pop in the same edge are both performed; count is unchanged.
  - When full, the write is still dropped even if a pop occurs that edge.
  - Pointers wrap modulo DEPTH.
- Scoreboard:
  - HAZ_DEPTH-entry shift register of {valid, rd}, shifted every RUN and DRAIN cycle.
  - A real issue shifts in {1, rd}.
  - A bubble, or a queued instruction with opcode 4'hf, shifts in {0, x}.
- Hazard:
  - Raised when the FIFO head's opcode is not 4'hf and its rs or rt equals rd of any valid scoreboard entry.
  - A producer followed directly by a dependent instruction therefore yields exactly HAZ_DEPTH bubbles between them.
- State machine:
  - IDLE:
    - instr=f000, issue_valid=0.
    - start=1 and empty=0 at the edge moves to RUN; nothing is issued on that edge.
    - start with empty=1 is ignored.
  - RUN, each edge:
    - empty=1: go to DRAIN with bubble-count=0; instr=f000.
    - Hazard: instr=f000, issue_valid=0, no pop.
    - Otherwise: pop the head, instr=head, issue_valid=(opcode!=4'hf).
    - Host writes during RUN are legal and are issued in order.
    - start is ignored while busy.
  - DRAIN:
    - instr=f000 for HAZ_DEPTH cycles.
    - Then done=1 for one cycle and return to IDLE.
    - A write arriving in DRAIN stays queued until the next start.
- Latency: start sampled at edge N; first instruction visible on instr after edge N+1.

Test Plan:
1. Reset: assert rst=1 mid-cycle -> instr=16'hf000, count=0, empty=1, full=0, busy=0, immediately without waiting for a clock edge.
2. Independent stream:
   - Stimulus: enqueue 0562, 1345, 69ab; pulse start at edge N.
   - Required: instr = 0562 / 1345 / 69ab after edges N+1/N+2/N+3, issue_valid=1 for each.
   - Then 3 f000 slots (DRAIN), done=1 for one cycle, busy=0.
3. RAW hazard:
   - Stimulus: enqueue 2678 (rd=8) then 2891 (rs=8).
   - Required: instr = 2678, f000, f000, f000, 2891; issue_valid = 1,0,0,0,1.
4. Queued no-op:
   - Stimulus: enqueue f000 then 0218 (rs=2).
   - Required: f000 is issued with issue_valid=0 and raises no hazard; 0218 is issued in the next slot.
5. Overflow:
   - Stimulus: write 9 instructions back-to-back in IDLE.
   - Required: full=1 after the 8th, count=8, 9th dropped, ovf_err=1.
   - After start and drain: count=0, ovf_err still 1.
6. Reset mid-run:
   - Stimulus: load 7cde, ccef, 2678; start; assert rst after the first issue.
   - Required: instr=f000, busy=0, count=0.
   - A new start after release with the FIFO still empty is ignored.
